agen_issue_arbiter: RTL and testbench

//  Shares the single address-generation datapath between NUM_REQ issue requesters
//    (default: load issue lane, store issue lane).

---
 rtl/agen_issue_arbiter_if.sv | 49 ++++
 rtl/agen_issue_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_agen_issue_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/agen_issue_arbiter_if.sv
// Shared operand widths, fission opcodes and the requester/AGEN signal bundle
// of the AGEN issue arbiter.
`ifndef AGEN_ISSUE_ARBITER_DEFS
`define AGEN_ISSUE_ARBITER_DEFS
`define SIZE_DATA       32
`define SIZE_IMMEDIATE  16
`define SIZE_OPCODE_I   6
`define OPC_LW          6'h01
`define OPC_SW          6'h02
`define OPC_DLW_L       6'h10
`define OPC_DLW_H       6'h11
`define OPC_DSW_L       6'h12
`define OPC_DSW_H       6'h13
`endif

// Handshake: requester op i moves when req_valid_i[i] & req_ready_o[i]; the registered
// op moves into AGEN when agen_valid_o & agen_ready_i and holds stable otherwise.
interface agen_issue_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 7
) ();
  localparam int SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                 req_valid_i;
  logic [NUM_REQ-1:0]                 req_ready_o;
  logic [NUM_REQ*`SIZE_DATA-1:0]      req_data1_i;
  logic [NUM_REQ*`SIZE_IMMEDIATE-1:0] req_immd_i;
  logic [NUM_REQ*`SIZE_OPCODE_I-1:0]  req_opcode_i;
  logic [NUM_REQ*TAG_W-1:0]           req_tag_i;
  logic                               agen_valid_o;
  logic                               agen_ready_i;
  logic [`SIZE_DATA-1:0]              agen_data1_o;
  logic [`SIZE_IMMEDIATE-1:0]         agen_immd_o;
  logic [`SIZE_OPCODE_I-1:0]          agen_opcode_o;
  logic [TAG_W-1:0]                   agen_tag_o;
  logic [SRC_W-1:0]                   agen_src_o;

  modport slave (
    input  req_valid_i, req_data1_i, req_immd_i, req_opcode_i, req_tag_i, agen_ready_i,
    output req_ready_o, agen_valid_o, agen_data1_o, agen_immd_o, agen_opcode_o,
           agen_tag_o, agen_src_o
  );

  modport master (
    output req_valid_i, req_data1_i, req_immd_i, req_opcode_i, req_tag_i, agen_ready_i,
    input  req_ready_o, agen_valid_o, agen_data1_o, agen_immd_o, agen_opcode_o,
           agen_tag_o, agen_src_o
  );
endinterface

// File: rtl/agen_issue_arbiter.sv
// Round-robin arbiter sharing one AGEN datapath among NUM_REQ issue lanes, with a
// registered output stage and an atomic-pair lock for fission (_L/_H) ops.
module agen_issue_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int TAG_W        = 7,
  parameter int LOCK_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush_i,
  agen_issue_arbiter_if.slave bus,
  output logic                lock_err_o,
  output logic                lock_dbg_o
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int DW    = `SIZE_DATA;
  localparam int IW    = `SIZE_IMMEDIATE;
  localparam int OW    = `SIZE_OPCODE_I;

  typedef enum logic {ST_OPEN = 1'b0, ST_LOCKED = 1'b1} lock_state_t;
  lock_state_t r_state, w_state_nxt;

  logic [IDX_W-1:0]   r_rr_ptr, r_lock_src, r_agen_src, w_winner, w_idx, w_rr_base;
  logic [CNT_W-1:0]   r_lock_cnt, w_cnt_nxt;
  logic               r_lock_store, r_lock_err, r_agen_valid;
  logic [DW-1:0]      r_agen_data1, w_data1;
  logic [IW-1:0]      r_agen_immd, w_immd;
  logic [OW-1:0]      r_agen_op, w_op;
  logic [TAG_W-1:0]   r_agen_tag, w_tag;
  logic [NUM_REQ-1:0] w_elig, w_ready;
  logic               w_load, w_found, w_xfer, w_src_valid, w_timeout;
  logic               w_is_l, w_h_match, w_lock_err_nxt, w_rr_adv;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                input logic [IDX_W:0]   b);
    logic [IDX_W:0] s;
    s = {1'b0, a} + b;
    if (s >= (IDX_W+1)'(NUM_REQ)) s = s - (IDX_W+1)'(NUM_REQ);
    return s[IDX_W-1:0];
  endfunction

  // Accepting is blocked while the output stage stalls, during flush and during reset.
  assign w_load      = reset_n && !flush_i && (!r_agen_valid || bus.agen_ready_i);
  assign w_src_valid = bus.req_valid_i[r_lock_src];

  always_comb begin
    w_elig = bus.req_valid_i;
    if (r_state == ST_LOCKED) begin
      w_elig             = '0;
      w_elig[r_lock_src] = w_src_valid;
    end
  end

  // Scan from the farthest slot back to rr_ptr so the nearest eligible index wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = wrap_add(r_rr_ptr, (IDX_W+1)'(k));
      if (w_elig[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_data1 = '0;
    w_immd  = '0;
    w_op    = '0;
    w_tag   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == IDX_W'(i)) begin
        w_data1 = bus.req_data1_i[i*DW +: DW];
        w_immd  = bus.req_immd_i[i*IW +: IW];
        w_op    = bus.req_opcode_i[i*OW +: OW];
        w_tag   = bus.req_tag_i[i*TAG_W +: TAG_W];
      end
    end
  end

  assign w_xfer    = w_load && w_found;
  assign w_is_l    = (w_op == `OPC_DLW_L) || (w_op == `OPC_DSW_L);
  assign w_h_match = r_lock_store ? (w_op == `OPC_DSW_H) : (w_op == `OPC_DLW_H);
  assign w_timeout = (r_state == ST_LOCKED) && !w_src_valid &&
                     (r_lock_cnt == CNT_W'(LOCK_TIMEOUT - 1));

  always_comb begin
    w_ready = '0;
    if (w_xfer) w_ready[w_winner] = 1'b1;
  end
  assign bus.req_ready_o = w_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_OPEN;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_lock_err_nxt = 1'b0;
    if (flush_i) begin
      w_state_nxt = ST_OPEN;
    end else begin
      case (r_state)
        ST_OPEN: begin
          if (w_xfer && w_is_l) w_state_nxt = ST_LOCKED;
        end
        ST_LOCKED: begin
          if (w_xfer) begin
            w_state_nxt    = ST_OPEN;
            w_lock_err_nxt = !w_h_match;
          end else if (w_timeout) begin
            w_state_nxt    = ST_OPEN;
            w_lock_err_nxt = 1'b1;
          end
        end
        default: w_state_nxt = ST_OPEN;
      endcase
    end
  end

  // Idle counting only runs while a lock is held across the cycle.
  always_comb begin
    w_cnt_nxt = '0;
    if (r_state == ST_LOCKED && w_state_nxt == ST_LOCKED && !w_src_valid &&
        r_lock_cnt != CNT_W'(LOCK_TIMEOUT))
      w_cnt_nxt = r_lock_cnt + 1'b1;
  end

  assign w_rr_adv  = !flush_i && (w_state_nxt == ST_OPEN) && (w_xfer || w_timeout);
  assign w_rr_base = w_xfer ? w_winner : r_lock_src;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rr_ptr     <= '0;
      r_lock_src   <= '0;
      r_lock_cnt   <= '0;
      r_lock_store <= 1'b0;
      r_lock_err   <= 1'b0;
      r_agen_valid <= 1'b0;
      r_agen_data1 <= '0;
      r_agen_immd  <= '0;
      r_agen_op    <= '0;
      r_agen_tag   <= '0;
      r_agen_src   <= '0;
    end else begin
      r_lock_err <= w_lock_err_nxt;
      r_lock_cnt <= w_cnt_nxt;
      if (w_rr_adv) r_rr_ptr <= wrap_add(w_rr_base, (IDX_W+1)'(1));
      if (r_state == ST_OPEN && w_state_nxt == ST_LOCKED) begin
        r_lock_src   <= w_winner;
        r_lock_store <= (w_op == `OPC_DSW_L);
      end
      if (flush_i) begin
        r_agen_valid <= 1'b0;
      end else if (w_load) begin
        r_agen_valid <= w_found;
        if (w_found) begin
          r_agen_data1 <= w_data1;
          r_agen_immd  <= w_immd;
          r_agen_op    <= w_op;
          r_agen_tag   <= w_tag;
          r_agen_src   <= w_winner;
        end
      end
    end
  end

  assign bus.agen_valid_o  = r_agen_valid;
  assign bus.agen_data1_o  = r_agen_data1;
  assign bus.agen_immd_o   = r_agen_immd;
  assign bus.agen_opcode_o = r_agen_op;
  assign bus.agen_tag_o    = r_agen_tag;
  assign bus.agen_src_o    = r_agen_src;
  assign lock_err_o        = r_lock_err;
  assign lock_dbg_o        = (r_state == ST_LOCKED);
endmodule

// File: tb/tb_agen_issue_arbiter.sv
// Bench for agen_issue_arbiter: directed scenarios with literal pins plus random
// traffic, all checked each cycle against a behavioural arbitration model.
`timescale 1ns/1ps
module tb_agen_issue_arbiter;
  localparam int NUM_REQ      = 2;
  localparam int TAG_W        = 7;
  localparam int LOCK_TIMEOUT = 15;
  localparam int DW   = `SIZE_DATA;
  localparam int IW   = `SIZE_IMMEDIATE;
  localparam int OW   = `SIZE_OPCODE_I;
  localparam int SRCW = $clog2(NUM_REQ);
  localparam int PW   = DW + IW + OW + TAG_W + SRCW;

  localparam int P_READY = 0, P_VALID = 1, P_SRC = 2, P_ERR = 3, P_LOCK = 4, P_TAG = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush_i = 1'b0;
  logic lock_err_o, lock_dbg_o;

  agen_issue_arbiter_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) bus ();

  agen_issue_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .flush_i(flush_i), .bus(bus),
    .lock_err_o(lock_err_o), .lock_dbg_o(lock_dbg_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct { int kind; logic [31:0] exp; } pin_t;
  pin_t           pin_q[$];
  logic [PW-1:0]  exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  bit m_valid = 0, m_lock = 0, m_err = 0, m_store = 0;
  int m_rr = 0, m_src = 0, m_cnt = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
    end
  endtask

  // ---------------- compare + model process ----------------
  always @(negedge clk) begin : compare
    int w;
    bit found, load, xfer, err;
    logic [NUM_REQ-1:0] exp_ready;
    logic [PW-1:0] got, pay;
    logic [OW-1:0] op;
    pin_t p;

    load  = reset_n && !flush_i && (!m_valid || bus.agen_ready_i);
    found = 0;
    w     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req_valid_i[(m_rr + k) % NUM_REQ] &&
          (!m_lock || ((m_rr + k) % NUM_REQ) == m_src)) begin
        found = 1;
        w     = (m_rr + k) % NUM_REQ;
      end
    end
    xfer = load && found;
    exp_ready = '0;
    if (xfer) exp_ready[w] = 1'b1;

    check("req_ready", 64'(bus.req_ready_o), 64'(exp_ready));
    check("agen_valid", 64'(bus.agen_valid_o), 64'(m_valid));
    check("lock_err", 64'(lock_err_o), 64'(m_err));
    check("lock_state", 64'(lock_dbg_o), 64'(m_lock));
    if (m_valid) begin
      got = {bus.agen_data1_o, bus.agen_immd_o, bus.agen_opcode_o, bus.agen_tag_o, bus.agen_src_o};
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_payload @%0t: got 0x%0h expected nothing queued", $time, got);
      end else begin
        check("sb_payload", 64'(got), 64'(exp_q[0]));
      end
    end

    while (pin_q.size() > 0) begin
      p = pin_q.pop_front();
      case (p.kind)
        P_READY: check("pin_ready", 64'(bus.req_ready_o), 64'(p.exp));
        P_VALID: check("pin_valid", 64'(bus.agen_valid_o), 64'(p.exp));
        P_SRC:   check("pin_src", 64'(bus.agen_src_o), 64'(p.exp));
        P_ERR:   check("pin_lock_err", 64'(lock_err_o), 64'(p.exp));
        P_LOCK:  check("pin_lock", 64'(lock_dbg_o), 64'(p.exp));
        default: check("pin_tag", 64'(bus.agen_tag_o), 64'(p.exp));
      endcase
    end

    // advance the model to what the coming clock edge must produce
    if (!reset_n) begin
      m_valid = 0; m_lock = 0; m_err = 0; m_store = 0;
      m_rr = 0; m_src = 0; m_cnt = 0;
      exp_q.delete();
    end else begin
      err = 0;
      if (m_valid && (flush_i || bus.agen_ready_i) && exp_q.size() > 0)
        void'(exp_q.pop_front());
      if (flush_i) begin
        m_valid = 0; m_lock = 0; m_cnt = 0;
      end else begin
        op = bus.req_opcode_i[w*OW +: OW];
        if (load) m_valid = found;
        if (xfer) begin
          pay = {bus.req_data1_i[w*DW +: DW], bus.req_immd_i[w*IW +: IW], op,
                 bus.req_tag_i[w*TAG_W +: TAG_W], SRCW'(w)};
          exp_q.push_back(pay);
        end
        if (m_lock) begin
          if (xfer) begin
            err    = (op != (m_store ? `OPC_DSW_H : `OPC_DLW_H));
            m_lock = 0;
            m_rr   = (w + 1) % NUM_REQ;
          end else if (!bus.req_valid_i[m_src]) begin
            m_cnt++;
            if (m_cnt >= LOCK_TIMEOUT) begin
              m_lock = 0; m_cnt = 0; err = 1;
              m_rr   = (m_src + 1) % NUM_REQ;
            end
          end else begin
            m_cnt = 0;
          end
        end else if (xfer) begin
          if (op == `OPC_DLW_L || op == `OPC_DSW_L) begin
            m_lock = 1; m_src = w; m_cnt = 0; m_store = (op == `OPC_DSW_L);
          end else begin
            m_rr = (w + 1) % NUM_REQ;
          end
        end
      end
      m_err = err;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input int kind, input logic [31:0] exp);
    pin_q.push_back('{kind, exp});
  endtask

  task automatic set_req(input int i, input bit v, input logic [OW-1:0] op,
                         input logic [TAG_W-1:0] tag);
    bus.req_valid_i[i]                = v;
    bus.req_opcode_i[i*OW +: OW]      = op;
    bus.req_tag_i[i*TAG_W +: TAG_W]   = tag;
    bus.req_data1_i[i*DW +: DW]       = $urandom;
    bus.req_immd_i[i*IW +: IW]        = IW'($urandom);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    flush_i = 1'b0;
    bus.agen_ready_i = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, `OPC_LW, '0);
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  function automatic logic [OW-1:0] pick_op();
    case ($urandom_range(0, 7))
      0: return `OPC_LW;
      1: return `OPC_SW;
      2: return `OPC_DLW_L;
      3: return `OPC_DLW_H;
      4: return `OPC_DSW_L;
      5: return `OPC_DSW_H;
      6: return 6'h2a;
      default: return `OPC_LW;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  logic [1:0] grant_seq [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  bit sparse;

  initial begin
    do_reset();
    pin(P_VALID, 0); pin(P_ERR, 0); pin(P_LOCK, 0); pin(P_SRC, 0); pin(P_READY, 0);
    tick();

    // alternating grants with both lanes busy
    bus.agen_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      set_req(0, 1'b1, `OPC_LW, TAG_W'(2*c));
      set_req(1, 1'b1, `OPC_SW, TAG_W'(2*c + 1));
      pin(P_READY, 32'(grant_seq[c]));
      if (c > 0) pin(P_SRC, 32'(c - 1) % 2);
      tick();
    end

    // output stall holds tag 0x12
    do_reset();
    set_req(0, 1'b1, `OPC_LW, 7'h12);
    pin(P_READY, 1);
    tick();
    set_req(0, 1'b1, `OPC_SW, 7'h13);
    set_req(1, 1'b1, `OPC_LW, 7'h21);
    repeat (3) begin
      pin(P_READY, 0); pin(P_VALID, 1); pin(P_TAG, 'h12);
      tick();
    end
    bus.agen_ready_i = 1'b1;
    pin(P_READY, 2); pin(P_TAG, 'h12);
    tick();
    set_req(1, 1'b0, `OPC_LW, 7'h00);
    pin(P_VALID, 1); pin(P_TAG, 'h21); pin(P_SRC, 1); pin(P_READY, 1);
    tick();

    // DLW pair stays atomic against a waiting lane
    do_reset();
    bus.agen_ready_i = 1'b1;
    set_req(0, 1'b1, `OPC_DLW_L, 7'h01);
    pin(P_READY, 1);
    tick();
    set_req(0, 1'b0, `OPC_LW, 7'h00);
    set_req(1, 1'b1, `OPC_LW, 7'h02);
    repeat (3) begin
      pin(P_READY, 0); pin(P_LOCK, 1);
      tick();
    end
    set_req(0, 1'b1, `OPC_DLW_H, 7'h03);
    pin(P_READY, 1);
    tick();
    set_req(0, 1'b0, `OPC_LW, 7'h00);
    pin(P_READY, 2); pin(P_LOCK, 0); pin(P_ERR, 0); pin(P_TAG, 'h03);
    tick();
    set_req(1, 1'b0, `OPC_LW, 7'h00);
    pin(P_SRC, 1); pin(P_TAG, 'h02);
    tick();

    // lock watchdog after DSW_L with lane 0 idle
    do_reset();
    bus.agen_ready_i = 1'b1;
    set_req(0, 1'b1, `OPC_DSW_L, 7'h04);
    pin(P_READY, 1);
    tick();
    set_req(0, 1'b0, `OPC_LW, 7'h00);
    set_req(1, 1'b1, `OPC_LW, 7'h05);
    for (int k = 1; k <= LOCK_TIMEOUT; k++) begin
      pin(P_READY, 0); pin(P_ERR, 0); pin(P_LOCK, 1);
      tick();
    end
    pin(P_ERR, 1); pin(P_LOCK, 0); pin(P_READY, 2);
    tick();
    set_req(1, 1'b0, `OPC_LW, 7'h00);
    pin(P_ERR, 0); pin(P_SRC, 1); pin(P_TAG, 'h05);
    tick();

    // wrong second half is forwarded and flagged
    do_reset();
    bus.agen_ready_i = 1'b1;
    set_req(0, 1'b1, `OPC_DLW_L, 7'h06);
    pin(P_READY, 1);
    tick();
    set_req(0, 1'b1, `OPC_LW, 7'h07);
    pin(P_READY, 1); pin(P_LOCK, 1);
    tick();
    set_req(0, 1'b0, `OPC_LW, 7'h00);
    pin(P_ERR, 1); pin(P_LOCK, 0); pin(P_VALID, 1); pin(P_TAG, 'h07);
    tick();
    pin(P_ERR, 0); pin(P_VALID, 0);
    tick();

    // flush during a locked stall, then reset during a locked stall
    do_reset();
    bus.agen_ready_i = 1'b1;
    set_req(0, 1'b1, `OPC_DSW_L, 7'h08);
    pin(P_READY, 1);
    tick();
    bus.agen_ready_i = 1'b0;
    set_req(0, 1'b0, `OPC_LW, 7'h00);
    set_req(1, 1'b1, `OPC_LW, 7'h09);
    pin(P_LOCK, 1); pin(P_VALID, 1); pin(P_READY, 0);
    tick();
    flush_i = 1'b1;
    pin(P_READY, 0);
    tick();
    flush_i = 1'b0;
    bus.agen_ready_i = 1'b1;
    pin(P_VALID, 0); pin(P_LOCK, 0); pin(P_ERR, 0); pin(P_READY, 2);
    tick();
    set_req(1, 1'b0, `OPC_LW, 7'h00);
    set_req(0, 1'b1, `OPC_LW, 7'h0a);
    pin(P_READY, 1);
    tick();
    set_req(0, 1'b0, `OPC_LW, 7'h00);
    set_req(1, 1'b1, `OPC_DLW_L, 7'h0b);
    pin(P_READY, 2);
    tick();
    bus.agen_ready_i = 1'b0;
    set_req(1, 1'b0, `OPC_LW, 7'h00);
    pin(P_LOCK, 1); pin(P_SRC, 1);
    tick();
    reset_n = 1'b0;
    pin(P_READY, 0);
    tick();
    pin(P_VALID, 0); pin(P_LOCK, 0); pin(P_ERR, 0); pin(P_SRC, 0);
    tick();
    reset_n = 1'b1;
    bus.agen_ready_i = 1'b1;
    set_req(0, 1'b1, `OPC_LW, 7'h0c);
    set_req(1, 1'b1, `OPC_LW, 7'h0d);
    pin(P_READY, 1);
    tick();

    // random traffic with dense and sparse phases
    sparse = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) sparse = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < NUM_REQ; i++)
        set_req(i, sparse ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) != 0),
                pick_op(), TAG_W'($urandom));
      bus.agen_ready_i = ($urandom_range(0, 3) != 0);
      flush_i          = ($urandom_range(0, 39) == 0);
      reset_n          = ($urandom_range(0, 499) != 0);
      tick();
    end
    reset_n = 1'b1;
    flush_i = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, `OPC_LW, '0);
    repeat (4) tick();

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
